// File: rtl/rsa_result_unloader.sv
// rsa_result_unloader: after the RSA core reports done, reads NUM_WORDS result
// words over the core read bus (oe_n/addr/result) and streams them out on a
// valid/ready port with a single-entry output buffer.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// WAIT_DONE | armed, waiting for done & status=ok, watching error/timeout
// READ      | oe_n low, addr stable, waiting RD_LAT cycles for result
// PUSH      | word held on out_* until downstream accepts it
// FINISH    | one-cycle completion pulse, then back to IDLE
module rsa_result_unloader #(
  parameter int               ADDR_W      = 8,
  parameter int               DATA_W      = 32,
  parameter int               NUM_WORDS   = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int               RD_LAT      = 1,
  parameter int               TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic [1:0]        status,
  output logic              oe_n,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  localparam int KW = $clog2(NUM_WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int RW = $clog2(RD_LAT) + 1;

  localparam logic [KW-1:0] K_LAST   = KW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(RD_LAT - 1);

  localparam logic [1:0] ST_OK  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    READ      = 3'd2,
    PUSH      = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [TW-1:0]   tmo;
  logic [RW-1:0]   rd_cnt;

  // Sequencer: all outputs are registered and updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      oe_n      <= 1'b1;
      addr      <= BASE_ADDR;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      error     <= 1'b0;
      k         <= '0;
      tmo       <= '0;
      rd_cnt    <= '0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_DONE;
            k     <= '0;
            tmo   <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
          end
        end

        WAIT_DONE: begin
          // Core error takes priority over a simultaneous done.
          if (status == ST_ERR) begin
            error    <= 1'b1;
            finished <= 1'b1;
            state    <= FINISH;
          end else if (done && status == ST_OK) begin
            state  <= READ;
            addr   <= BASE_ADDR + ADDR_W'(k);
            oe_n   <= 1'b0;
            rd_cnt <= '0;
          end else if (tmo == TMO_LAST) begin
            error    <= 1'b1;
            finished <= 1'b1;
            state    <= FINISH;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        READ: begin
          if (rd_cnt == RD_LAST) begin
            out_data  <= result;
            oe_n      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= (k == K_LAST);
            state     <= PUSH;
          end else begin
            rd_cnt <= rd_cnt + RW'(1);
          end
        end

        PUSH: begin
          // Next core read only starts once the buffered word is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (k == K_LAST) begin
              finished <= 1'b1;
              state    <= FINISH;
            end else begin
              k      <= k + KW'(1);
              addr   <= BASE_ADDR + ADDR_W'(k + KW'(1));
              oe_n   <= 1'b0;
              rd_cnt <= '0;
              state  <= READ;
            end
          end
        end

        FINISH: begin
          oe_n      <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          oe_n      <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_result_unloader.sv
// Directed bench for rsa_result_unloader: two instances (base 0 with a long
// timeout, base FE with a 16-cycle timeout) share clock, reset and core bus
// inputs; each has its own start and a small combinational core memory.
module tb_rsa_result_unloader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        done = 1'b0;
  logic [1:0]  status = 2'b00;
  logic        out_ready = 1'b1;

  logic        oe_n_a, oe_n_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] result_a, result_b;
  logic [31:0] out_data_a, out_data_b;
  logic        out_valid_a, out_valid_b;
  logic        out_last_a, out_last_b;
  logic        busy_a, busy_b;
  logic        finished_a, finished_b;
  logic        error_a, error_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t nom_tbl[4];
  vec_t wrap_tbl[4];

  logic [7:0]  addr_q_a[$], addr_q_b[$];
  logic [32:0] word_q_a[$], word_q_b[$];
  int          fin_a = 0, fin_b = 0;

  always #5 clk = ~clk;

  // core memory: word at address x is A5A5_0000 + x
  assign result_a = oe_n_a ? 32'hDEAD_BEEF : {24'hA5A500, addr_a};
  assign result_b = oe_n_b ? 32'hDEAD_BEEF : {24'hA5A500, addr_b};

  rsa_result_unloader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4), .BASE_ADDR(8'h00),
                        .RD_LAT(1), .TIMEOUT_CYC(64)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done(done), .status(status),
    .oe_n(oe_n_a), .addr(addr_a), .result(result_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a),
    .busy(busy_a), .finished(finished_a), .error(error_a));

  rsa_result_unloader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4), .BASE_ADDR(8'hFE),
                        .RD_LAT(1), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done), .status(status),
    .oe_n(oe_n_b), .addr(addr_b), .result(result_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b),
    .busy(busy_b), .finished(finished_b), .error(error_b));

  // record core reads, accepted words and completion pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (!oe_n_a) addr_q_a.push_back(addr_a);
      if (!oe_n_b) addr_q_b.push_back(addr_b);
      if (out_valid_a && out_ready) word_q_a.push_back({out_last_a, out_data_a});
      if (out_valid_b && out_ready) word_q_b.push_back({out_last_b, out_data_b});
      if (finished_a) fin_a++;
      if (finished_b) fin_b++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fin(input bit b, input int bound, input string name);
    int  c0;
    bit  seen;
    c0   = b ? fin_b : fin_a;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((b ? fin_b : fin_a) != c0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: finished not seen within %0d cycles", name, bound);
    end
    tick();
  endtask

  task automatic check_run(input bit b, input string name);
    int   na, nw;
    vec_t v;
    na = b ? addr_q_b.size() : addr_q_a.size();
    nw = b ? word_q_b.size() : word_q_a.size();
    chk({name, " read count"}, na, 4);
    chk({name, " word count"}, nw, 4);
    for (int i = 0; i < 4; i++) begin
      v = b ? wrap_tbl[i] : nom_tbl[i];
      if (i < na) chk({name, " addr"}, b ? addr_q_b[i] : addr_q_a[i], {24'h0, v.addr});
      if (i < nw) begin
        chk({name, " data"}, b ? word_q_b[i][31:0] : word_q_a[i][31:0], v.data);
        chk({name, " last"}, b ? word_q_b[i][32] : word_q_a[i][32], {31'h0, v.last});
      end
    end
  endtask

  task automatic clear_q();
    addr_q_a.delete(); addr_q_b.delete();
    word_q_a.delete(); word_q_b.delete();
  endtask

  initial begin
    int f0;
    bit got;
    int early;

    for (int i = 0; i < 4; i++) begin
      nom_tbl[i].addr  = 8'(i);
      nom_tbl[i].data  = 32'hA5A5_0000 + 32'(i);
      nom_tbl[i].last  = (i == 3);
      wrap_tbl[i].addr = 8'hFE + 8'(i);
      wrap_tbl[i].data = 32'hA5A5_0000 + {24'h0, 8'hFE + 8'(i)};
      wrap_tbl[i].last = (i == 3);
    end

    // power-on reset values
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst oe_n", oe_n_a, 1);
    chk("rst addr", addr_a, 0);
    chk("rst addr base FE", addr_b, 32'hFE);
    chk("rst out_valid", out_valid_a, 0);
    chk("rst out_last", out_last_a, 0);
    chk("rst out_data", out_data_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst finished", finished_a, 0);
    chk("rst error", error_a, 0);
    tick();

    // reset held 3 cycles while in READ
    start_a = 1'b1; done = 1'b1; status = 2'b10; out_ready = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("mid-read oe_n low", oe_n_a, 0);
    rst = 1'b1;
    tick();
    chk("mid-read rst oe_n", oe_n_a, 1);
    chk("mid-read rst out_valid", out_valid_a, 0);
    chk("mid-read rst busy", busy_a, 0);
    chk("mid-read rst addr", addr_a, 0);
    tick(); tick();
    rst = 1'b0; done = 1'b0; status = 2'b00;
    tick();
    clear_q();

    // nominal: done+ok 20 cycles after start, ready tied high
    f0 = fin_a;
    status = 2'b01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("nominal busy", busy_a, 1);
    repeat (20) tick();
    chk("nominal no read before done", addr_q_a.size(), 0);
    done = 1'b1; status = 2'b10;
    wait_fin(1'b0, 40, "nominal");
    done = 1'b0; status = 2'b00;
    repeat (3) tick();
    check_run(1'b0, "nominal");
    chk("nominal finished pulses", fin_a - f0, 1);
    chk("nominal busy after", busy_a, 0);
    chk("nominal error", error_a, 0);
    clear_q();

    // backpressure on word 1 for 5 cycles
    f0 = fin_a;
    status = 2'b01; out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    done = 1'b1; status = 2'b10;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_q_a.size() >= 1) begin got = 1'b1; break; end
    end
    chk("bp word0 accepted", {31'h0, got}, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid held", out_valid_a, 1);
      chk("bp data held", out_data_a, 32'hA5A5_0001);
      chk("bp oe_n high", oe_n_a, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_fin(1'b0, 40, "backpressure");
    done = 1'b0; status = 2'b00;
    repeat (3) tick();
    check_run(1'b0, "backpressure");
    chk("bp finished pulses", fin_a - f0, 1);
    clear_q();

    // core error after 10 cycles of waiting
    f0 = fin_a;
    status = 2'b01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    status = 2'b11;
    wait_fin(1'b0, 10, "core error");
    status = 2'b00;
    repeat (3) tick();
    chk("core error flag", error_a, 1);
    chk("core error words", word_q_a.size(), 0);
    chk("core error reads", addr_q_a.size(), 0);
    chk("core error finished pulses", fin_a - f0, 1);
    clear_q();

    // timeout: finished exactly 16 cycles after the start edge
    f0 = fin_b;
    status = 2'b01; done = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    early = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (finished_b) early++;
    end
    tick();
    chk("timeout early finished", early, 0);
    chk("timeout finished at 16", finished_b, 1);
    chk("timeout error", error_b, 1);
    tick();
    chk("timeout finished one cycle", finished_b, 0);
    chk("timeout reads", addr_q_b.size(), 0);

    // wrap from FE, start during PUSH ignored, start clears error
    f0 = fin_b;
    out_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("wrap start clears error", error_b, 0);
    repeat (3) tick();
    done = 1'b1; status = 2'b10;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_b) begin got = 1'b1; break; end
    end
    chk("wrap first word valid", {31'h0, got}, 1);
    @(posedge clk); #1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    out_ready = 1'b1;
    wait_fin(1'b1, 40, "wrap");
    done = 1'b0; status = 2'b00;
    repeat (5) tick();
    check_run(1'b1, "wrap");
    chk("wrap finished pulses", fin_b - f0, 1);
    chk("wrap error", error_b, 0);
    chk("wrap busy after", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
